// File: rtl/change_sequencer_if.sv
// change_sequencer_if: groups the front-end, keypad and coin-release
// signals of the change sequencer. The front end (coin acceptor, keypad,
// actuator) uses the master modport and the sequencer uses the slave modport.
interface change_sequencer_if;
  logic       CoinValid;
  logic [2:0] CoinType;
  logic [3:0] Cost;
  logic       Buy;
  logic       Cancel;
  logic       DispReady;
  logic       CoinReject;
  logic       DispValid;
  logic [2:0] DispCoin;
  logic [3:0] Paid;
  logic [1:0] Pentagons;
  logic [1:0] Triangles;
  logic [1:0] Circles;
  logic       Vend;
  logic       ExactAmount;
  logic       CoughUpMore;
  logic       NotEnoughChange;
  logic       Refunded;
  logic [7:0] SalesTotal;

  modport master (
    output CoinValid, CoinType, Cost, Buy, Cancel, DispReady,
    input  CoinReject, DispValid, DispCoin, Paid, Pentagons, Triangles, Circles,
    input  Vend, ExactAmount, CoughUpMore, NotEnoughChange, Refunded, SalesTotal
  );

  modport slave (
    input  CoinValid, CoinType, Cost, Buy, Cancel, DispReady,
    output CoinReject, DispValid, DispCoin, Paid, Pentagons, Triangles, Circles,
    output Vend, ExactAmount, CoughUpMore, NotEnoughChange, Refunded, SalesTotal
  );
endinterface

// File: rtl/change_sequencer.sv
// change_sequencer: collects coins, keeps the coin inventory, solves for the
// fewest-coin change (ties broken towards more pentagons) and releases coins
// one per DispValid/DispReady handshake. Coin values: circle 1, triangle 3,
// pentagon 5. Optional sales accumulator enabled by CHANGE_SEQ_AUDIT_EN.
module change_sequencer #(
  parameter int INIT_P  = 2,
  parameter int INIT_T  = 2,
  parameter int INIT_C  = 2,
  parameter int TIMEOUT = 100
) (
  input  logic              clock,
  input  logic              reset,
  change_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_SOLVE    = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic [2:0] COIN_C = 3'b001;
  localparam logic [2:0] COIN_T = 3'b010;
  localparam logic [2:0] COIN_P = 3'b100;

  // Pentagons first, then triangles, then circles.
  function automatic logic [2:0] next_coin(input logic [1:0] p, input logic [1:0] t,
                                           input logic [1:0] c);
    if (p != 2'd0)      return COIN_P;
    else if (t != 2'd0) return COIN_T;
    else if (c != 2'd0) return COIN_C;
    else                return 3'b000;
  endfunction

  state_e      state_q;
  logic [3:0]  paid_q, target_q, cost_q;
  logic [1:0]  pent_q, trng_q, circ_q;
  logic [1:0]  plan_p_q, plan_t_q, plan_c_q;
  logic        refund_q;
  logic [15:0] tmo_q;
  logic        coin_reject_q, disp_valid_q, vend_q, exact_q, more_q, nec_q, refunded_q;
  logic [2:0]  disp_coin_q;

  logic [3:0]  coin_val_s;
  logic [1:0]  coin_cnt_s;
  logic        coin_legal_s, coin_ok_s, tmo_hit_s;
  logic [15:0] tmo_next_s;
  logic        sol_found_s;
  logic [1:0]  sol_p_s, sol_t_s, sol_c_s;
  logic [4:0]  best_s, cnt_s;
  logic signed [6:0] c_s;
  logic [2:0]  first_coin_s, nxt_coin_s;
  logic [1:0]  rem_p_s, rem_t_s, rem_c_s;

  // Decode the inserted coin and decide whether it can be accepted.
  always_comb begin
    coin_val_s   = 4'd0;
    coin_cnt_s   = 2'd3;
    coin_legal_s = 1'b0;
    case (bus.CoinType)
      COIN_C:  begin coin_val_s = 4'd1; coin_cnt_s = circ_q; coin_legal_s = 1'b1; end
      COIN_T:  begin coin_val_s = 4'd3; coin_cnt_s = trng_q; coin_legal_s = 1'b1; end
      COIN_P:  begin coin_val_s = 4'd5; coin_cnt_s = pent_q; coin_legal_s = 1'b1; end
      default: begin coin_val_s = 4'd0; coin_cnt_s = 2'd3;   coin_legal_s = 1'b0; end
    endcase
    coin_ok_s = coin_legal_s && (({1'b0, paid_q} + {1'b0, coin_val_s}) <= 5'd15) &&
                (coin_cnt_s != 2'd3);
  end

  // Idle-credit timer: a full idle period with credit held acts as Cancel.
  always_comb begin
    if (paid_q != 4'd0) begin
      tmo_next_s = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
    end else begin
      tmo_next_s = 16'd0;
    end
    tmo_hit_s = (TIMEOUT != 0) && (paid_q != 4'd0) && !bus.Cancel && !bus.Buy &&
                !(bus.CoinValid && coin_ok_s) &&
                (({16'd0, tmo_q} + 32'd1) == 32'(TIMEOUT));
  end

  // Exhaustive change search; descending p with strict improvement keeps larger p on ties.
  always_comb begin
    sol_found_s = 1'b0;
    sol_p_s     = 2'd0;
    sol_t_s     = 2'd0;
    sol_c_s     = 2'd0;
    best_s      = 5'h1F;
    c_s         = 7'sd0;
    cnt_s       = 5'd0;
    for (int pi = 3; pi >= 0; pi--) begin
      for (int ti = 0; ti <= 3; ti++) begin
        c_s   = $signed({3'b000, target_q}) - $signed(7'(5 * pi)) - $signed(7'(3 * ti));
        cnt_s = 5'(pi) + 5'(ti) + c_s[4:0];
        if ((3'(pi) <= {1'b0, pent_q}) && (3'(ti) <= {1'b0, trng_q}) &&
            (c_s >= 7'sd0) && (c_s <= $signed({5'b00000, circ_q})) && (cnt_s < best_s)) begin
          sol_found_s = 1'b1;
          best_s      = cnt_s;
          sol_p_s     = 2'(pi);
          sol_t_s     = 2'(ti);
          sol_c_s     = c_s[1:0];
        end else begin
          sol_found_s = sol_found_s;
        end
      end
    end
    first_coin_s = next_coin(sol_p_s, sol_t_s, sol_c_s);
  end

  // Plan that remains once the presented coin is taken, and the coin that follows it.
  always_comb begin
    rem_p_s = plan_p_q;
    rem_t_s = plan_t_q;
    rem_c_s = plan_c_q;
    case (disp_coin_q)
      COIN_P:  rem_p_s = plan_p_q - 2'd1;
      COIN_T:  rem_t_s = plan_t_q - 2'd1;
      COIN_C:  rem_c_s = plan_c_q - 2'd1;
      default: rem_p_s = plan_p_q;
    endcase
    nxt_coin_s = next_coin(rem_p_s, rem_t_s, rem_c_s);
  end

  // Sequencer FSM: credit, inventory, plan and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_COLLECT;
      paid_q        <= 4'd0;
      target_q      <= 4'd0;
      cost_q        <= 4'd0;
      pent_q        <= 2'(INIT_P);
      trng_q        <= 2'(INIT_T);
      circ_q        <= 2'(INIT_C);
      plan_p_q      <= 2'd0;
      plan_t_q      <= 2'd0;
      plan_c_q      <= 2'd0;
      refund_q      <= 1'b0;
      tmo_q         <= 16'd0;
      coin_reject_q <= 1'b0;
      disp_valid_q  <= 1'b0;
      disp_coin_q   <= 3'b000;
      vend_q        <= 1'b0;
      exact_q       <= 1'b0;
      more_q        <= 1'b0;
      nec_q         <= 1'b0;
      refunded_q    <= 1'b0;
    end else begin
      coin_reject_q <= bus.CoinValid && (state_q != ST_COLLECT);
      vend_q        <= 1'b0;
      exact_q       <= 1'b0;
      more_q        <= 1'b0;
      nec_q         <= 1'b0;
      refunded_q    <= 1'b0;
      case (state_q)
        ST_COLLECT: begin
          if (bus.Cancel || tmo_hit_s) begin
            tmo_q         <= 16'd0;
            coin_reject_q <= bus.CoinValid;
            if (paid_q != 4'd0) begin
              target_q <= paid_q;
              refund_q <= 1'b1;
              state_q  <= ST_SOLVE;
            end
          end else if (bus.Buy) begin
            tmo_q         <= 16'd0;
            coin_reject_q <= bus.CoinValid;
            if (paid_q < bus.Cost) begin
              more_q <= 1'b1;
            end else begin
              cost_q   <= bus.Cost;
              target_q <= paid_q - bus.Cost;
              refund_q <= 1'b0;
              state_q  <= ST_SOLVE;
            end
          end else if (bus.CoinValid && coin_ok_s) begin
            tmo_q  <= 16'd0;
            paid_q <= paid_q + coin_val_s;
            case (bus.CoinType)
              COIN_C:  circ_q <= circ_q + 2'd1;
              COIN_T:  trng_q <= trng_q + 2'd1;
              COIN_P:  pent_q <= pent_q + 2'd1;
              default: circ_q <= circ_q;
            endcase
          end else begin
            tmo_q         <= tmo_next_s;
            coin_reject_q <= bus.CoinValid;
          end
        end
        ST_SOLVE: begin
          if (sol_found_s || refund_q) begin
            plan_p_q <= sol_p_s;
            plan_t_q <= sol_t_s;
            plan_c_q <= sol_c_s;
            if (first_coin_s == 3'b000) begin
              paid_q     <= 4'd0;
              state_q    <= ST_DONE;
              refunded_q <= refund_q;
              vend_q     <= !refund_q;
              exact_q    <= !refund_q && (target_q == 4'd0);
            end else begin
              disp_valid_q <= 1'b1;
              disp_coin_q  <= first_coin_s;
              state_q      <= ST_DISPENSE;
            end
          end else begin
            // Change cannot be paid out: fall back to refunding the credit.
            nec_q    <= 1'b1;
            target_q <= paid_q;
            refund_q <= 1'b1;
          end
        end
        ST_DISPENSE: begin
          if (bus.DispReady) begin
            plan_p_q <= rem_p_s;
            plan_t_q <= rem_t_s;
            plan_c_q <= rem_c_s;
            case (disp_coin_q)
              COIN_P:  pent_q <= pent_q - 2'd1;
              COIN_T:  trng_q <= trng_q - 2'd1;
              COIN_C:  circ_q <= circ_q - 2'd1;
              default: pent_q <= pent_q;
            endcase
            disp_coin_q <= nxt_coin_s;
            if (nxt_coin_s == 3'b000) begin
              disp_valid_q <= 1'b0;
              paid_q       <= 4'd0;
              state_q      <= ST_DONE;
              refunded_q   <= refund_q;
              vend_q       <= !refund_q;
              exact_q      <= !refund_q && (target_q == 4'd0);
            end
          end
        end
        ST_DONE:  state_q <= ST_COLLECT;
        default:  state_q <= ST_COLLECT;
      endcase
    end
  end

`ifdef CHANGE_SEQ_AUDIT_EN
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [7:0] sales_q;

  // Running sales total, credited with the latched cost once per Vend.
  always_ff @(posedge clock) begin
    if (reset) begin
      sales_q <= 8'd0;
    end else if (vend_q) begin
      sales_q <= sat_add(sales_q, cost_q);
    end
  end

  assign bus.SalesTotal = sales_q;
`else
  assign bus.SalesTotal = 8'h00;
`endif

  assign bus.CoinReject      = coin_reject_q;
  assign bus.DispValid       = disp_valid_q;
  assign bus.DispCoin        = disp_coin_q;
  assign bus.Paid            = paid_q;
  assign bus.Pentagons       = pent_q;
  assign bus.Triangles       = trng_q;
  assign bus.Circles         = circ_q;
  assign bus.Vend            = vend_q;
  assign bus.ExactAmount     = exact_q;
  assign bus.CoughUpMore     = more_q;
  assign bus.NotEnoughChange = nec_q;
  assign bus.Refunded        = refunded_q;

endmodule

// File: tb/tb_change_sequencer.sv
// tb_change_sequencer: directed scenarios plus randomized traffic, every
// cycle compared against a transaction-level model (coin queue, brute-force
// change search) kept in this file.
module tb_change_sequencer;
  localparam int TMO = 4;
  localparam logic [2:0] C_P = 3'b100;
  localparam logic [2:0] C_T = 3'b010;
  localparam logic [2:0] C_C = 3'b001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  change_sequencer_if bus();
  change_sequencer #(.INIT_P(2), .INIT_T(2), .INIT_C(2), .TIMEOUT(TMO)) dut (
    .clock(clk), .reset(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int ph;                 // 0 taking coins, 1 solving, 2 paying out, 3 wrap-up
  int paid, target, cost, idle, sales;
  int inv[3];             // 0 pentagon, 1 triangle, 2 circle
  bit refund;
  logic [2:0] plan[$];
  bit e_rej, e_vend, e_exact, e_more, e_nec, e_ref;
  int vals[3] = '{5, 3, 1};
  logic [2:0] codes[3] = '{3'b100, 3'b010, 3'b001};

  function automatic int coin_idx(input logic [2:0] c);
    for (int i = 0; i < 3; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic solve_change(input int tgt, output bit found);
    int bn, bp, bt, bc;
    bn = 99; bp = 0; bt = 0; bc = 0; found = 0;
    for (int p = 0; p <= inv[0]; p++)
      for (int t = 0; t <= inv[1]; t++)
        for (int c = 0; c <= inv[2]; c++)
          if (5 * p + 3 * t + c == tgt && (p + t + c < bn || (p + t + c == bn && p > bp))) begin
            bn = p + t + c; bp = p; bt = t; bc = c; found = 1;
          end
    plan.delete();
    if (found) begin
      repeat (bp) plan.push_back(C_P);
      repeat (bt) plan.push_back(C_T);
      repeat (bc) plan.push_back(C_C);
    end
  endtask

  task automatic settle();
    paid = 0;
    ph   = 3;
    if (refund) e_ref = 1;
    else begin e_vend = 1; e_exact = (target == 0); end
  endtask

  task automatic model_step();
    int k; bit acc, fire, found;
`ifdef CHANGE_SEQ_AUDIT_EN
    if (!rst && e_vend) sales = (sales + cost > 255) ? 255 : sales + cost;
`endif
    e_rej = 0; e_vend = 0; e_exact = 0; e_more = 0; e_nec = 0; e_ref = 0;
    if (rst) begin
      ph = 0; paid = 0; target = 0; cost = 0; idle = 0; sales = 0; refund = 0;
      inv = '{2, 2, 2};
      plan.delete();
    end else begin
      if (ph != 0 && bus.CoinValid) e_rej = 1;
      case (ph)
        0: begin
          k = coin_idx(bus.CoinType);
          if (bus.CoinValid && k >= 0) acc = (paid + vals[k] <= 15) && (inv[k] < 3);
          else acc = 0;
          fire = (TMO != 0) && paid > 0 && !bus.Cancel && !bus.Buy && !acc && (idle + 1 == TMO);
          if (bus.Cancel || fire) begin
            idle = 0; e_rej = bus.CoinValid;
            if (paid > 0) begin target = paid; refund = 1; ph = 1; end
          end else if (bus.Buy) begin
            idle = 0; e_rej = bus.CoinValid;
            if (paid < bus.Cost) e_more = 1;
            else begin cost = bus.Cost; target = paid - bus.Cost; refund = 0; ph = 1; end
          end else if (acc) begin
            idle = 0; paid += vals[k]; inv[k]++;
          end else begin
            e_rej = bus.CoinValid;
            idle  = (paid > 0) ? idle + 1 : 0;
          end
        end
        1: begin
          solve_change(target, found);
          if (found || refund) begin
            if (plan.size() == 0) settle();
            else ph = 2;
          end else begin
            e_nec = 1; target = paid; refund = 1;
          end
        end
        2: begin
          if (bus.DispReady) begin
            inv[coin_idx(plan[0])]--;
            void'(plan.pop_front());
            if (plan.size() == 0) settle();
          end
        end
        default: ph = 0;
      endcase
    end
  endtask

  // ---------------- per-cycle driver and checks ----------------
  int n_vend = 0, n_exact = 0, n_more = 0, n_nec = 0, n_ref = 0, n_rej = 0;
  logic [2:0] coin_log[$];

  task automatic tick();
    logic [2:0] edc;
    if (bus.DispValid === 1'b1 && bus.DispReady && !rst) coin_log.push_back(bus.DispCoin);
    @(posedge clk);
    model_step();
    @(negedge clk);
    edc = (ph == 2) ? plan[0] : 3'b000;
    check_eq("CoinReject", 32'(bus.CoinReject), 32'(e_rej));
    check_eq("DispValid", 32'(bus.DispValid), 32'(ph == 2));
    check_eq("DispCoin", 32'(bus.DispCoin), 32'(edc));
    check_eq("Paid", 32'(bus.Paid), paid);
    check_eq("Pentagons", 32'(bus.Pentagons), inv[0]);
    check_eq("Triangles", 32'(bus.Triangles), inv[1]);
    check_eq("Circles", 32'(bus.Circles), inv[2]);
    check_eq("Vend", 32'(bus.Vend), 32'(e_vend));
    check_eq("ExactAmount", 32'(bus.ExactAmount), 32'(e_exact));
    check_eq("CoughUpMore", 32'(bus.CoughUpMore), 32'(e_more));
    check_eq("NotEnoughChange", 32'(bus.NotEnoughChange), 32'(e_nec));
    check_eq("Refunded", 32'(bus.Refunded), 32'(e_ref));
    check_eq("SalesTotal", 32'(bus.SalesTotal), sales);
    n_vend += 32'(bus.Vend); n_exact += 32'(bus.ExactAmount); n_more += 32'(bus.CoughUpMore);
    n_nec += 32'(bus.NotEnoughChange); n_ref += 32'(bus.Refunded); n_rej += 32'(bus.CoinReject);
  endtask

  task automatic set_idle();
    bus.CoinValid = 1'b0; bus.CoinType = 3'b000; bus.Cost = 4'd0;
    bus.Buy = 1'b0; bus.Cancel = 1'b0; bus.DispReady = 1'b1;
  endtask

  task automatic do_reset();
    set_idle(); rst = 1'b1; tick(); tick(); rst = 1'b0;
    coin_log.delete();
  endtask

  task automatic insert(input logic [2:0] c);
    bus.CoinValid = 1'b1; bus.CoinType = c; tick(); bus.CoinValid = 1'b0;
  endtask

  task automatic buy(input logic [3:0] c);
    bus.Cost = c; bus.Buy = 1'b1; tick(); bus.Buy = 1'b0;
  endtask

  // Waits for Vend or Refunded, then lets the sequencer return to coin taking.
  task automatic wait_done(input string tag, input int limit);
    bit got; got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      got = bus.Vend || bus.Refunded;
    end
    check_eq({tag, "_done_in_time"}, 32'(got), 32'd1);
    tick();
  endtask

  function automatic logic [11:0] pack_log();
    logic [11:0] p; p = 12'd0;
    foreach (coin_log[i]) p = {p[8:0], coin_log[i]};
    return p;
  endfunction

  int v0, x0, m0, ne0, r0, j0;
  int exp_sales;

  initial begin
    rst = 1'b1;
    set_idle();
    do_reset();
    check_eq("reset_paid", 32'(bus.Paid), 32'd0);
    check_eq("reset_pent", 32'(bus.Pentagons), 32'd2);

    // Scenario 1: change 7 from P3/T3/C2 pays out P, C, C.
    v0 = n_vend; x0 = n_exact;
    insert(C_P); insert(C_T);
    check_eq("s1_paid8", 32'(bus.Paid), 32'd8);
    buy(4'd1);
    wait_done("s1", 20);
    check_eq("s1_coins", 32'(pack_log()), 32'h109);
    check_eq("s1_ncoins", coin_log.size(), 3);
    check_eq("s1_vend", n_vend - v0, 1);
    check_eq("s1_exact", n_exact - x0, 0);
    check_eq("s1_inv", {bus.Pentagons, bus.Triangles, bus.Circles}, 32'({2'd2, 2'd3, 2'd0}));
    check_eq("s1_paid0", 32'(bus.Paid), 32'd0);

    // Scenario 2: no circles left, so change 2 fails and 5 is refunded as a pentagon.
    coin_log.delete(); ne0 = n_nec; r0 = n_ref;
    insert(C_P);
    check_eq("s2_pent3", 32'(bus.Pentagons), 32'd3);
    buy(4'd3);
    wait_done("s2", 20);
    check_eq("s2_nec", n_nec - ne0, 1);
    check_eq("s2_refund", n_ref - r0, 1);
    check_eq("s2_coins", 32'(pack_log()), 32'h004);
    check_eq("s2_pent2", 32'(bus.Pentagons), 32'd2);

    // Scenario 3: insufficient credit, then cancel.
    do_reset(); m0 = n_more; r0 = n_ref;
    insert(C_T);
    buy(4'd5);
    check_eq("s3_more", n_more - m0, 1);
    check_eq("s3_paid3", 32'(bus.Paid), 32'd3);
    bus.Cancel = 1'b1; tick(); bus.Cancel = 1'b0;
    wait_done("s3", 20);
    check_eq("s3_coins", 32'(pack_log()), 32'h002);
    check_eq("s3_refund", n_ref - r0, 1);

    // Scenario 4: full circle slot rejects; coin alongside Buy is rejected.
    do_reset(); j0 = n_rej; v0 = n_vend; x0 = n_exact;
    insert(C_C); insert(C_C);
    check_eq("s4_rej", n_rej - j0, 1);
    check_eq("s4_paid1", 32'(bus.Paid), 32'd1);
    bus.CoinValid = 1'b1; bus.CoinType = C_P;
    buy(4'd1);
    bus.CoinValid = 1'b0;
    check_eq("s4_rej_buy", n_rej - j0, 2);
    wait_done("s4", 10);
    check_eq("s4_vend_exact", (n_vend - v0) * 10 + (n_exact - x0), 11);

    // Scenario 5: exact amount, Vend two cycles after Buy.
    do_reset();
    insert(C_P);
    buy(4'd5);
    tick();
    check_eq("s5_vend", 32'(bus.Vend), 32'd1);
    check_eq("s5_exact", 32'(bus.ExactAmount), 32'd1);
    check_eq("s5_nodisp", 32'(bus.DispValid), 32'd0);
    tick(); tick();
`ifdef CHANGE_SEQ_AUDIT_EN
    exp_sales = 5;
`else
    exp_sales = 0;
`endif
    check_eq("s5_sales", 32'(bus.SalesTotal), exp_sales);

    // Scenario 6: stalled actuator, reset mid-dispense, then idle timeout.
    do_reset();
    insert(C_P); insert(C_T);
    bus.DispReady = 1'b0;
    buy(4'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.CoinValid = 1'b1; bus.CoinType = C_C;
      tick();
      check_eq("s6_stall_coin", 32'(bus.DispCoin), 32'(C_P));
      check_eq("s6_stall_rej", 32'(bus.CoinReject), 32'd1);
    end
    bus.CoinValid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("s6_rst_valid", 32'(bus.DispValid), 32'd0);
    check_eq("s6_rst_inv", {bus.Pentagons, bus.Triangles, bus.Circles}, 32'({2'd2, 2'd2, 2'd2}));
    check_eq("s6_rst_paid", 32'(bus.Paid), 32'd0);
    set_idle(); r0 = n_ref; coin_log.delete();
    insert(C_C);
    wait_done("s6_timeout", 3 * TMO + 6);
    check_eq("s6_tmo_refund", n_ref - r0, 1);
    check_eq("s6_tmo_coins", 32'(pack_log()), 32'h001);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst = ($urandom_range(0, 499) == 0);
      bus.CoinValid = ($urandom_range(0, 99) < 45);
      r = $urandom_range(0, 9);
      if (r < 3)      bus.CoinType = C_P;
      else if (r < 6) bus.CoinType = C_T;
      else if (r < 9) bus.CoinType = C_C;
      else            bus.CoinType = 3'($urandom_range(0, 7));
      bus.Buy       = ($urandom_range(0, 99) < 8);
      bus.Cost      = 4'($urandom_range(0, 15));
      bus.Cancel    = ($urandom_range(0, 99) < 3);
      bus.DispReady = ($urandom_range(0, 99) < 70);
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
